core_overlap_splitter: RTL
==========================

Name: core_overlap_splitter

Overview:
- Feeds the four-core tile array. Accepts the input feature map one column per transfer.
- Duplicates the overlapping halo rows and columns, then drives all four core input ports in lockstep with one valid.
- It is the scatter (overlap-split) counterpart of the overlap-add post-processor that merges the four core outputs back into one column stream.
- Core 0 = left/low, core 1 = right/low, core 2 = left/high, core 3 = right/high.

Parameters:
- SIZE_OF_EACH_CORE_INPUT, 2, per-core input tile edge.
- SIZE_OF_EACH_KERNEL, 3, kernel edge.
- STRIDE, 1, convolution stride.
- PIX_WIDTH, 8, bits per pixel.
- NON_OVERLAPPED_CONST (N), SIZE_OF_EACH_CORE_INPUT*STRIDE, row/column offset between adjacent cores.
- SIZE_OF_PRSC_INPUT (P_IN), STRIDE*(SIZE_OF_EACH_CORE_INPUT-1)+SIZE_OF_EACH_KERNEL, pixels per core column and columns per core tile.
- SIZE_OF_PRSC_OUTPUT (P_OUT), P_IN+N, pixels per input column and columns per input tile.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- en_i  in  1  global enable; low freezes all state
- valid_i  in  1  column_i valid
- ready_o  out  1  splitter can accept column_i
- column_i  in  PIX_WIDTH*P_OUT  input column; pixel j at [j*PIX_WIDTH +: PIX_WIDTH]
- core_data_0_o  out  PIX_WIDTH*P_IN  left column, pixels 0..P_IN-1
- core_data_1_o  out  PIX_WIDTH*P_IN  right column, pixels 0..P_IN-1
- core_data_2_o  out  PIX_WIDTH*P_IN  left column, pixels N..P_OUT-1
- core_data_3_o  out  PIX_WIDTH*P_IN  right column, pixels N..P_OUT-1
- valid_o  out  1  all four core outputs valid
- ready_i  in  1  core array accepts outputs
- last_o  out  1  qualifies the final emission of a tile (valid with valid_o)

Behaviour:
- Clock and reset: one clock clk_i. Reset is asynchronous and active-low on rst_i.
- Reset values: col_cnt=0, delay pointer=0, valid_o=0, last_o=0, all core_data_*_o=0, delay buffer contents don't-care.
- Accept condition: a column is accepted when en_i && valid_i && ready_o.
- Column counter col_cnt:
  - Runs 0..P_OUT-1 and increments per accepted column.
  - Wraps to 0 after P_OUT-1; the next tile begins immediately, with no idle cycle.
- Delay buffer: N entries of PIX_WIDTH*P_OUT, single pointer ptr, modulo N.
  - On each accept: read entry[ptr] (column col_cnt-N), write column_i into entry[ptr], advance ptr.
  - The read returns the old contents (read-before-write).
- Phases:
  - FILL (col_cnt<N): accept and store only; no emission. ready_o=en_i.
  - EMIT (col_cnt>=N): each accept loads the output register with left column = entry[ptr], right column = column_i. Emission index k = col_cnt-N; there are P_IN emissions per tile.
- Output register:
  - valid_o sets on an EMIT accept and clears on valid_o && ready_i with no new load.
  - In EMIT, ready_o = en_i && (!valid_o || ready_i), i.e. a one-deep pipeline.
  - Back-to-back throughput is 1 column/clk while ready_i=1.
  - Outputs hold stable while valid_o && !ready_i.
- Latency: column N+k accepted at edge t -> emission k visible after edge t (registered, 1 cycle).
- last_o = 1 with the emission loaded by accept of col_cnt=P_OUT-1.
- Slicing:
  - core0 = left[0 +: P_IN*PIX_WIDTH]; core2 = left[N*PIX_WIDTH +: P_IN*PIX_WIDTH].
  - core1/core3 are the same slices of the right column.
  - Overlap rows P_IN-N are duplicated, never summed. No arithmetic; widths pass through.
- en_i low: no accept, no counter or pointer movement, valid_o and data held. ready_i handshakes are ignored while en_i low (valid_o is not cleared).
- Reset mid-tile: all partial-tile state is discarded; the next accepted column is column 0 of a new tile.
- Emission with P_IN<N (unused geometry): not supported. P_IN>=N holds for all legal parameter sets.

Test Plan:
All scenarios use defaults (N=2, P_IN=4, P_OUT=6). Column c pixel j = 16c+j, hex.
1. Reset release, stream columns 0..5 with ready_i=1:
   - ready_o=1 throughout; valid_o first high after column 2 accept.
   - Emission 0: core0={03,02,01,00}, core2={05,04,03,02}, core1={23,22,21,20}, core3={25,24,23,22}.
   - Exactly 4 emissions (left cols 0..3 paired with right cols 2..5); last_o only on the 4th.
2. Two tiles back-to-back (12 columns): tile-2 emission 0 pairs input columns 6 and 8 (tile-local col 0 and col 2); no bubble between tiles.
3. ready_i=0 for 3 cycles during emission 1:
   - ready_o drops to 0 and outputs stay frozen at {col1 | col3} slices.
   - Resumes with no loss or duplication.
4. en_i=0 for 2 cycles mid-FILL and mid-EMIT, valid_i held high: no accept and counters static; the final emission set is identical to scenario 1.
5. Assert rst_i=0 after column 3 accepted, then stream columns 0..5: valid_o=0 immediately on reset; the new tile reproduces scenario 1 exactly.
6. valid_i gaps (every other cycle): emissions are identical to scenario 1 and valid_o deasserts between emissions when ready_i=1.

Source files
------------

// File: rtl/core_overlap_splitter.sv
// Overlap splitter for the 2x2 core tile array: buffers N columns, duplicates the halo
// rows/columns and drives the four core inputs in lockstep behind a one-deep output register.
module core_overlap_splitter #(
    parameter int SIZE_OF_EACH_CORE_INPUT = 2,
    parameter int SIZE_OF_EACH_KERNEL     = 3,
    parameter int STRIDE                  = 1,
    parameter int PIX_WIDTH               = 8,
    parameter int NON_OVERLAPPED_CONST    = SIZE_OF_EACH_CORE_INPUT * STRIDE,
    parameter int SIZE_OF_PRSC_INPUT      = STRIDE * (SIZE_OF_EACH_CORE_INPUT - 1) + SIZE_OF_EACH_KERNEL,
    parameter int SIZE_OF_PRSC_OUTPUT     = SIZE_OF_PRSC_INPUT + NON_OVERLAPPED_CONST
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        en_i,
    input  logic                                        valid_i,
    output logic                                        ready_o,
    input  logic [PIX_WIDTH*SIZE_OF_PRSC_OUTPUT-1:0]    column_i,
    output logic [PIX_WIDTH*SIZE_OF_PRSC_INPUT-1:0]     core_data_0_o,
    output logic [PIX_WIDTH*SIZE_OF_PRSC_INPUT-1:0]     core_data_1_o,
    output logic [PIX_WIDTH*SIZE_OF_PRSC_INPUT-1:0]     core_data_2_o,
    output logic [PIX_WIDTH*SIZE_OF_PRSC_INPUT-1:0]     core_data_3_o,
    output logic                                        valid_o,
    input  logic                                        ready_i,
    output logic                                        last_o
);

    localparam int N     = NON_OVERLAPPED_CONST;
    localparam int P_IN  = SIZE_OF_PRSC_INPUT;
    localparam int P_OUT = SIZE_OF_PRSC_OUTPUT;
    localparam int COL_W = PIX_WIDTH * P_OUT;
    localparam int OUT_W = PIX_WIDTH * P_IN;
    localparam int CNT_W = (P_OUT > 1) ? $clog2(P_OUT) : 1;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0] col_cnt_r;
    logic [PTR_W-1:0] ptr_r;
    logic [COL_W-1:0] dly_mem_r [N];

    logic             valid_r;
    logic             last_r;
    logic [OUT_W-1:0] core0_r;
    logic [OUT_W-1:0] core1_r;
    logic [OUT_W-1:0] core2_r;
    logic [OUT_W-1:0] core3_r;

    logic             emit_phase_s;
    logic             ready_s;
    logic             accept_s;
    logic             drain_s;
    logic             last_col_s;
    logic             last_ptr_s;
    logic [COL_W-1:0] left_col_s;

    // Handshake and phase decode; the FILL phase never waits on the core array.
    always_comb begin
        emit_phase_s = 1'b0;
        ready_s      = 1'b0;
        accept_s     = 1'b0;
        drain_s      = 1'b0;
        last_col_s   = 1'b0;
        last_ptr_s   = 1'b0;
        left_col_s   = dly_mem_r[ptr_r];

        emit_phase_s = (col_cnt_r >= CNT_W'(N));
        last_col_s   = (col_cnt_r == CNT_W'(P_OUT - 1));
        last_ptr_s   = (ptr_r == PTR_W'(N - 1));

        if (!en_i) begin
            ready_s = 1'b0;
        end else if (!emit_phase_s) begin
            ready_s = 1'b1;
        end else begin
            ready_s = !valid_r || ready_i;
        end

        accept_s = ready_s && valid_i;
        drain_s  = en_i && valid_r && ready_i;
    end

    // Column counter and delay pointer; both wrap so the next tile starts without a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_cnt_r <= '0;
            ptr_r     <= '0;
        end else if (accept_s) begin
            col_cnt_r <= last_col_s ? '0 : col_cnt_r + CNT_W'(1);
            ptr_r     <= last_ptr_s ? '0 : ptr_r + PTR_W'(1);
        end else begin
            col_cnt_r <= col_cnt_r;
            ptr_r     <= ptr_r;
        end
    end

    // Delay line storage; contents need no reset since FILL overwrites every entry before use.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            dly_mem_r[ptr_r] <= column_i;
        end
    end

    // Output register: left = column col_cnt-N (old entry), right = incoming column.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            core0_r <= '0;
            core1_r <= '0;
            core2_r <= '0;
            core3_r <= '0;
        end else if (accept_s && emit_phase_s) begin
            valid_r <= 1'b1;
            last_r  <= last_col_s;
            core0_r <= left_col_s[0 +: OUT_W];
            core1_r <= column_i[0 +: OUT_W];
            core2_r <= left_col_s[N*PIX_WIDTH +: OUT_W];
            core3_r <= column_i[N*PIX_WIDTH +: OUT_W];
        end else if (drain_s) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= valid_r;
            last_r  <= last_r;
        end
    end

    assign ready_o       = ready_s;
    assign valid_o       = valid_r;
    assign last_o        = last_r;
    assign core_data_0_o = core0_r;
    assign core_data_1_o = core1_r;
    assign core_data_2_o = core2_r;
    assign core_data_3_o = core3_r;

endmodule
